otter_mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read memory between the instruction-fetch and data ports of `otter_mcu`. This lets a unified-memory build run from one physical RAM instead of a dual-port behavioural array. Each cycle the block grants one requester, steers address, write data and strobes to the memory, and returns read data one cycle later on the granted port's response channel. A per-cycle owner tag tracks each in-flight read.

---
 rtl/otter_arb_pkg.sv | 13 +
 rtl/otter_mem_arbiter_if.sv | 41 ++++
 rtl/otter_arb_starve_ctr.sv | 29 ++
 rtl/otter_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_otter_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types for the otter unified-memory arbiter.
// No logic; no latency; no backpressure.
package otter_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Fetch, data and memory channels of the otter memory arbiter.
// No logic; latency and backpressure are defined by the arbiter (req/gnt).
interface otter_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [31:0]       o_if_rdata;

    logic              i_d_req;
    logic              i_d_we;
    logic [3:0]        i_d_sel;
    logic [ADDR_W-1:0] i_d_addr;
    logic [31:0]       i_d_wdata;
    logic              o_d_gnt;
    logic              o_d_rvalid;
    logic [31:0]       o_d_rdata;

    logic              o_mem_en;
    logic [3:0]        o_mem_we;
    logic [ADDR_W-3:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_sel, i_d_addr, i_d_wdata, i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
               o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    // Requester / memory side.
    modport master (
        output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_sel, i_d_addr, i_d_wdata, i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
               o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/otter_arb_starve_ctr.sv
// Saturating 4-bit count of denied fetch cycles; only exists with OTTER_ARB_FAIRNESS_EN.
// at_limit is a decode of the registered count; clr wins over inc; no backpressure.
`ifdef OTTER_ARB_FAIRNESS_EN
module otter_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [3:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 4'd0;
        end else if (clr) begin
            cnt_q <= 4'd0;
        end else if (inc && (cnt_q != 4'hF)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign at_limit = (cnt_q == 4'(LIMIT));

endmodule
`endif

// File: rtl/otter_mem_arbiter.sv
// Shares one sync-read RAM between fetch and data ports; OTTER_ARB_FAIRNESS_EN adds fetch anti-starvation.
// Grant is combinational (0 cycles); read data returns 1 cycle after grant.
// Backpressure: the losing requester sees gnt low and holds req until granted.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    otter_mem_arbiter_if.slave bus
);

    logic              run_q;
    owner_e            owner_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              if_gnt;
    logic              d_gnt;
    logic              fetch_boost;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Data normally wins; a pending fairness boost hands a contested cycle to fetch.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (run_q) begin
            if (bus.i_d_req && !(fetch_boost && bus.i_if_req)) begin
                d_gnt = 1'b1;
            end else if (bus.i_if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

`ifdef OTTER_ARB_FAIRNESS_EN
    logic starve_at_limit;
    logic boost_q;

    otter_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .inc      (run_q && bus.i_if_req && !if_gnt),
        .clr      (if_gnt || starve_at_limit),
        .at_limit (starve_at_limit)
    );

    // Reaching the limit arms the boost for the following cycle; any fetch grant disarms it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            boost_q <= 1'b0;
        end else if (if_gnt) begin
            boost_q <= 1'b0;
        end else if (starve_at_limit) begin
            boost_q <= 1'b1;
        end
    end

    assign fetch_boost = boost_q;
`else
    localparam int starve_limit_unused = STARVE_LIMIT;
    assign fetch_boost = 1'b0;
`endif

    always_comb begin
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (d_gnt) begin
            mem_addr  = bus.i_d_addr[ADDR_W-1:2];
            mem_wdata = bus.i_d_wdata;
            if (bus.i_d_we) begin
                mem_we = bus.i_d_sel;
            end
        end else if (if_gnt) begin
            mem_addr = bus.i_if_addr[ADDR_W-1:2];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q      <= 1'b0;
            owner_q    <= OWN_NONE;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            run_q <= 1'b1;
            if (if_gnt) begin
                owner_q <= OWN_IF;
            end else if (d_gnt && !bus.i_d_we) begin
                owner_q <= OWN_D;
            end else begin
                owner_q <= OWN_NONE;
            end
            if (owner_q == OWN_IF) begin
                if_rdata_q <= bus.i_mem_rdata;
            end
            if (owner_q == OWN_D) begin
                d_rdata_q <= bus.i_mem_rdata;
            end
        end
    end

    // RAM output is only valid in the response cycle, so it is passed through then and held after.
    assign bus.o_if_rvalid = (owner_q == OWN_IF);
    assign bus.o_d_rvalid  = (owner_q == OWN_D);
    assign bus.o_if_rdata  = (owner_q == OWN_IF) ? bus.i_mem_rdata : if_rdata_q;
    assign bus.o_d_rdata   = (owner_q == OWN_D)  ? bus.i_mem_rdata : d_rdata_q;

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_d_gnt     = d_gnt;
    assign bus.o_mem_en    = if_gnt | d_gnt;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.i_if_addr[1:0], bus.i_d_addr[1:0]};

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a behavioural sync-read RAM.
module tb_otter_mem_arbiter;

    localparam logic [31:0] A_F0  = 32'h8000_1000;
    localparam logic [31:0] A_F1  = 32'h8000_1004;
    localparam logic [31:0] A_D0  = 32'h8000_2000;
    localparam logic [31:0] A_BW  = 32'h8000_3000;
    localparam logic [31:0] A_BBF = 32'h8000_4000;
    localparam logic [31:0] A_BBD = 32'h8000_5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    otter_mem_arbiter_if #(.ADDR_W(32)) bus ();

    otter_mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [31:0] mem [logic [29:0]];
    logic [31:0] mw;

    function automatic logic [29:0] key(input logic [31:0] a);
        return a[31:2];
    endfunction

    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we == 4'b0000) begin
                bus.i_mem_rdata <= mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : 32'h0;
            end else begin
                mw = mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (bus.o_mem_we[b]) mw[8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
                mem[bus.o_mem_addr] = mw;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.i_if_req  = 1'b0;
        bus.i_if_addr = 32'h0;
        bus.i_d_req   = 1'b0;
        bus.i_d_we    = 1'b0;
        bus.i_d_sel   = 4'b0000;
        bus.i_d_addr  = 32'h0;
        bus.i_d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = A_F0;
        bus.i_d_req   = 1'b1;
        bus.i_d_we    = 1'b1;
        bus.i_d_sel   = 4'b1111;
        bus.i_d_addr  = A_D0;
        bus.i_d_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_if_gnt, bus.o_d_gnt, bus.o_mem_en} !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=000", {bus.o_if_gnt, bus.o_d_gnt, bus.o_mem_en});
        end
        checks++;
        if ({bus.o_if_rvalid, bus.o_d_rvalid} !== 2'b00 || bus.o_if_rdata !== 32'h0 || bus.o_d_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_resp got=%b/%h/%h exp=00/0/0", {bus.o_if_rvalid, bus.o_d_rvalid}, bus.o_if_rdata, bus.o_d_rdata);
        end
        checks++;
        if (bus.o_mem_we !== 4'h0 || bus.o_mem_addr !== 30'h0 || bus.o_mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_mem got=%h/%h/%h exp=0/0/0", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
        end
        tick();
        rst_n = 1'b1;
        idle_reqs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        tick();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = A_F0;
        @(negedge clk);
        checks++;
        if (bus.o_if_gnt !== 1'b1) begin
            failures++; $display("FAIL midrst_gnt got=%b exp=1", bus.o_if_gnt);
        end
        #2;
        rst_n = 1'b0;
        idle_reqs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_if_rvalid !== 1'b0) begin
                failures++; $display("FAIL midrst_rvalid cyc=%0d got=%b exp=0", c, bus.o_if_rvalid);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({bus.o_if_rvalid, bus.o_d_rvalid} !== 2'b00 || bus.o_if_rdata !== 32'h0 || bus.o_d_rdata !== 32'h0) begin
            failures++; $display("FAIL midrst_after got=%b/%h/%h exp=00/0/0", {bus.o_if_rvalid, bus.o_d_rvalid}, bus.o_if_rdata, bus.o_d_rdata);
        end
    endtask

    task automatic test_single_fetch();
        tick();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = A_F0;
        @(negedge clk);
        checks++;
        if ({bus.o_if_gnt, bus.o_d_gnt, bus.o_mem_en} !== 3'b101 || bus.o_mem_addr !== key(A_F0) || bus.o_mem_we !== 4'h0) begin
            failures++; $display("FAIL fetch_gnt got=%b addr=%h we=%h exp=101 addr=%h we=0",
                {bus.o_if_gnt, bus.o_d_gnt, bus.o_mem_en}, bus.o_mem_addr, bus.o_mem_we, key(A_F0));
        end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 32'h0000_0013 || bus.o_d_rvalid !== 1'b0) begin
            failures++; $display("FAIL fetch_resp got=%b/%h exp=1/00000013", bus.o_if_rvalid, bus.o_if_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.o_if_rvalid !== 1'b0 || bus.o_if_rdata !== 32'h0000_0013) begin
            failures++; $display("FAIL fetch_hold got=%b/%h exp=0/00000013", bus.o_if_rvalid, bus.o_if_rdata);
        end
    endtask

    task automatic test_contention();
        tick();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = A_F1;
        bus.i_d_req   = 1'b1;
        bus.i_d_addr  = A_D0;
        @(negedge clk);
        checks++;
        if ({bus.o_if_gnt, bus.o_d_gnt} !== 2'b01 || bus.o_mem_addr !== key(A_D0)) begin
            failures++; $display("FAIL cont_gnt got=%b addr=%h exp=01 addr=%h", {bus.o_if_gnt, bus.o_d_gnt}, bus.o_mem_addr, key(A_D0));
        end
        tick();
        bus.i_d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_d_rvalid !== 1'b1 || bus.o_d_rdata !== 32'hDEAD_BEEF || bus.o_if_rvalid !== 1'b0) begin
            failures++; $display("FAIL cont_dresp got=%b/%h exp=1/deadbeef", bus.o_d_rvalid, bus.o_d_rdata);
        end
        checks++;
        if (bus.o_if_gnt !== 1'b1 || bus.o_mem_addr !== key(A_F1)) begin
            failures++; $display("FAIL cont_retry got=%b addr=%h exp=1 addr=%h", bus.o_if_gnt, bus.o_mem_addr, key(A_F1));
        end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 32'hA5A5_0001 || bus.o_d_rvalid !== 1'b0 || bus.o_d_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL cont_iresp got=%b/%h d=%b/%h exp=1/a5a50001 d=0/deadbeef",
                bus.o_if_rvalid, bus.o_if_rdata, bus.o_d_rvalid, bus.o_d_rdata);
        end
    endtask

    task automatic test_byte_write();
        tick();
        bus.i_d_req   = 1'b1;
        bus.i_d_we    = 1'b1;
        bus.i_d_sel   = 4'b0010;
        bus.i_d_addr  = A_BW;
        bus.i_d_wdata = 32'h0000_AB00;
        @(negedge clk);
        checks++;
        if (bus.o_d_gnt !== 1'b1 || bus.o_mem_we !== 4'b0010 || bus.o_mem_wdata !== 32'h0000_AB00) begin
            failures++; $display("FAIL bw_write got=%b we=%b wd=%h exp=1 we=0010 wd=0000ab00", bus.o_d_gnt, bus.o_mem_we, bus.o_mem_wdata);
        end
        tick();
        bus.i_d_we  = 1'b0;
        bus.i_d_sel = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.o_d_rvalid !== 1'b0 || bus.o_mem_we !== 4'b0000 || bus.o_d_gnt !== 1'b1) begin
            failures++; $display("FAIL bw_noresp got=%b we=%b gnt=%b exp=0 we=0000 gnt=1", bus.o_d_rvalid, bus.o_mem_we, bus.o_d_gnt);
        end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (bus.o_d_rvalid !== 1'b1 || bus.o_d_rdata !== 32'h1122_AB44) begin
            failures++; $display("FAIL bw_read got=%b/%h exp=1/1122ab44", bus.o_d_rvalid, bus.o_d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_if = 32'hA5A5_0001;
        logic [31:0] exp_d  = 32'h1122_AB44;
        int pulses = 0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            idle_reqs();
            if (k < 8 && (k % 2) == 0) begin
                bus.i_if_req  = 1'b1;
                bus.i_if_addr = A_BBF + 32'(4 * k);
            end else if (k < 8) begin
                bus.i_d_req  = 1'b1;
                bus.i_d_addr = A_BBD + 32'(4 * k);
            end
            @(negedge clk);
            if (k < 8) begin
                checks++;
                if ({bus.o_if_gnt, bus.o_d_gnt} !== (((k % 2) == 0) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL b2b_gnt k=%0d got=%b", k, {bus.o_if_gnt, bus.o_d_gnt});
                end
            end
            if (k > 0) begin
                if (((k - 1) % 2) == 0) exp_if = 32'h1000 + 32'(k - 1);
                else                    exp_d  = 32'h2000 + 32'(k - 1);
                pulses += int'(bus.o_if_rvalid) + int'(bus.o_d_rvalid);
                checks++;
                if ({bus.o_if_rvalid, bus.o_d_rvalid} !== ((((k - 1) % 2) == 0) ? 2'b10 : 2'b01) ||
                    bus.o_if_rdata !== exp_if || bus.o_d_rdata !== exp_d) begin
                    failures++; $display("FAIL b2b_resp k=%0d got=%b %h/%h exp %h/%h",
                        k, {bus.o_if_rvalid, bus.o_d_rvalid}, bus.o_if_rdata, bus.o_d_rdata, exp_if, exp_d);
                end
            end
        end
        checks++;
        if (pulses !== 8) begin
            failures++; $display("FAIL b2b_pulses got=%0d exp=8", pulses);
        end
        idle_reqs();
    endtask

    task automatic test_fairness();
        int first = -1;
        int expect_first;
        logic both = 1'b0;
`ifdef OTTER_ARB_FAIRNESS_EN
        expect_first = 5;
`else
        expect_first = -1;
`endif
        tick();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = A_F0;
        bus.i_d_req   = 1'b1;
        bus.i_d_addr  = A_D0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_if_gnt && bus.o_d_gnt) both = 1'b1;
            if (bus.o_if_gnt && first < 0) first = c;
            tick();
            if (first >= 0) bus.i_if_req = 1'b0;
        end
        checks++;
        if (first !== expect_first) begin
            failures++; $display("FAIL fair_first got=%0d exp=%0d", first, expect_first);
        end
        checks++;
        if (both !== 1'b0) begin
            failures++; $display("FAIL fair_onehot got=%b exp=0", both);
        end
        idle_reqs();
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_reqs();
        mem[key(A_F0)] = 32'h0000_0013;
        mem[key(A_F1)] = 32'hA5A5_0001;
        mem[key(A_D0)] = 32'hDEAD_BEEF;
        mem[key(A_BW)] = 32'h1122_3344;
        for (int k = 0; k < 8; k++) begin
            mem[key(A_BBF + 32'(4 * k))] = 32'h1000 + 32'(k);
            mem[key(A_BBD + 32'(4 * k))] = 32'h2000 + 32'(k);
        end
        test_reset();
        test_reset_mid_read();
        test_single_fetch();
        test_contention();
        test_byte_write();
        test_back_to_back();
        test_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
